// File: rtl/pipeline_arb_pkg.sv
// Shared types and width helpers for the pipeline share arbiter.
// Tag ids are sized for the largest supported requester count so the struct stays fixed.
package pipeline_arb_pkg;

    localparam int ID_W_MAX = 3;

    typedef struct packed {
        logic                vld;
        logic [ID_W_MAX-1:0] id;
    } tag_t;

    function automatic int id_w(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

    function automatic int cnt_w(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr wins.
// Produces the one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);

    always_comb begin
        logic [IDW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = IDW'((int'(ptr) + i) % N);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/pipeline_share_arbiter.sv
// Shares a fixed-latency non-stallable pipe between NREQ requesters with round-robin issue.
// A tag shift register aligned to the pipe latency routes each result back to its requester.
module pipeline_share_arbiter
    import pipeline_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int LATENCY = 3,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0] req_ready,
    output logic            pipe_in_valid,
    output logic [W-1:0]    pipe_in_data,
    input  logic            pipe_out_valid,
    input  logic [W-1:0]    pipe_out_data,
    output logic [NREQ-1:0] resp_valid,
    output logic [W-1:0]    resp_data,
    output logic            busy,
    output logic            err_orphan
);

    localparam int ID_W  = id_w(NREQ);
    localparam int CNT_W = cnt_w(MAX_OUT);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  pick;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  gnt;
    logic             any;
    logic             issue;
    logic [CNT_W-1:0] cnt [NREQ];
    tag_t             tags [LATENCY];
    tag_t             tail;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUT));
        end
    end

    rr_arbiter #(.N(NREQ), .IDW(ID_W)) u_rr (
        .req     (elig),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (pick),
        .any     (any)
    );

    // Outputs are forced quiet while rst is held, since the arbiter itself is combinational.
    assign issue         = any && !rst;
    assign req_ready     = rst ? '0 : gnt;
    assign pipe_in_valid = issue;
    assign pipe_in_data  = req_data[int'(pick)*W +: W];
    assign tail          = tags[LATENCY-1];
    assign resp_data     = pipe_out_data;

    always_comb begin
        resp_valid = '0;
        busy       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            resp_valid[i] = tail.vld && (tail.id == ID_W_MAX'(i)) && !rst;
            busy          = busy | (cnt[i] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) tags[k] <= '0;
        end else begin
            tags[0] <= '{vld: issue, id: ID_W_MAX'(pick)};
            for (int k = 1; k < LATENCY; k++) tags[k] <= tags[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (issue) begin
            ptr <= (int'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
        end
    end

    // Same-cycle issue and retire on one requester leaves its count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (issue && pick == ID_W'(i) && !(tail.vld && tail.id == ID_W_MAX'(i))) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!(issue && pick == ID_W'(i)) && tail.vld && tail.id == ID_W_MAX'(i)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_orphan <= 1'b0;
        end else if (pipe_out_valid != tail.vld) begin
            err_orphan <= 1'b1;
        end
    end

endmodule
